muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide/remainder, sitting beside the Execute-stage ALU.
- Accepts one operation when Execute holds a valid M-extension instruction and requests a pipeline stall until the result is ready.
- Presents the result for exactly one consumption, which Execute muxes into the execute/memory payload result field.
- Iterative radix-2 datapath: one shared 64-bit accumulator, a shift counter and a 4-state FSM.

Parameters:
- WIDTH, 32, operand/result width; the counter is clog2(WIDTH) bits and the iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  Execute holds a valid M-op, not flushed; sampled only in IDLE.
- operation  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  WIDTH  rs1 value.
- operandB  input  WIDTH  rs2 value.
- flush  input  1  Execute-stage flush; abort.
- stall  input  1  Execute-stage stall from downstream; holds DONE.
- stallRequest  output  1  combinational; OR'd into the Execute stall.
- resultValid  output  1  high in DONE.
- result  output  WIDTH  final value, stable while resultValid.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, counter=0, accumulator=0, result=0, resultValid=0; stallRequest then evaluates to start&&!flush.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE + start + !flush:
  - Latch magnitudes of A/B (signed per op: MUL low half treats both as unsigned; MULH both signed; MULHSU A signed; DIV/REM both signed).
  - Latch the result sign flags and the op; counter=WIDTH-1.
  - Go to RUN.
- Special cases short-circuit IDLE -> DONE in one cycle, with no RUN/FIXUP:
  - Division by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = operandA.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- RUN, one iteration per cycle:
  - Multiply: shift-add, 64-bit product.
  - Divide: restoring shift-subtract; quotient in low half, remainder in high half.
  - Counter decrements; at counter==0 go to FIXUP.
- FIXUP:
  - Apply two's-complement negation per the latched sign flags. Quotient sign = signA^signB; remainder sign = signA; product sign = signA^signB.
  - Select the low word (MUL, DIV/DIVU) or the high word (MULH*, REM*) into result.
  - Go to DONE.
- Latency: start seen in cycle N -> RUN N+1..N+WIDTH -> FIXUP N+WIDTH+1 -> DONE N+WIDTH+2 (N+34 at WIDTH=32). Special cases: DONE at N+1.
- stallRequest = (IDLE && start && !flush) || RUN || FIXUP. It is low in DONE so Execute advances and captures result that cycle.
- DONE:
  - resultValid=1.
  - If !stall -> IDLE next cycle; the result is consumed exactly once.
  - If stall -> remain in DONE, holding result and resultValid.
  - start is ignored in DONE.
- flush in any state: IDLE next cycle, resultValid=0, counter=0. A start coincident with flush is not accepted. flush beats stall.
- Operand changes after acceptance have no effect; all inputs are latched at start.
- Back-to-back M-ops: DONE consumed in cycle M, IDLE at M+1, next start accepted at M+1.
- resultValid and result are registered outputs; stallRequest is the only combinational output.
- Reset asserted mid-RUN: immediate return to the reset values; no partial result ever appears.

Test Plan:
- MUL A=7, B=0xFFFFFFFD -> DONE at N+34, result=0xFFFFFFEB, stallRequest high N..N+33 and low at N+34.
- MULH A=B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU A=0x1234, B=0 -> 0xFFFFFFFF at N+1; REM A=0x1234, B=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM of the same -> 0.
- stall held 5 cycles in DONE -> result/resultValid stable all 5 cycles, IDLE the cycle after stall drops; a second start that next cycle -> accepted.
- flush at RUN cycle 10 -> IDLE next cycle, resultValid never asserts; reset low at RUN cycle 20 -> all outputs 0 immediately, new op after release completes with the correct value.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 RV32M multiply/divide/remainder unit beside the Execute ALU.
// It accepts one op in IDLE, stalls Execute while it runs and offers the result for one cycle in DONE.
//
// state | meaning
// IDLE  | waiting for an accepted M-op
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIXUP | sign correction and word select into result
// DONE  | result valid; held while Execute is stalled
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  input  logic             stall,
  output logic             stallRequest,
  output logic             resultValid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        counter;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div;
  logic                 take_high;
  logic                 negate;

  logic                 in_div;
  logic                 a_signed;
  logic                 b_signed;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 neg_in;
  logic                 high_in;
  logic                 div_zero;
  logic                 overflow;
  logic [WIDTH-1:0]     special_val;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     word;
  logic [WIDTH-1:0]     word_fix;
  logic [WIDTH-1:0]     fixed;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Operand decode for the op being offered in IDLE.
  always_comb begin
    in_div   = operation[2];
    a_signed = (operation == 3'b001) || (operation == 3'b010) ||
               (operation == 3'b100) || (operation == 3'b110);
    b_signed = (operation == 3'b001) || (operation == 3'b100) || (operation == 3'b110);
    sign_a   = a_signed & operandA[WIDTH-1];
    sign_b   = b_signed & operandB[WIDTH-1];
    mag_a    = sign_a ? (~operandA + 1'b1) : operandA;
    mag_b    = sign_b ? (~operandB + 1'b1) : operandB;
    // Remainder takes the dividend sign; everything else the product/quotient sign.
    neg_in   = (operation == 3'b110) ? sign_a : (sign_a ^ sign_b);
    high_in  = operation[2] ? operation[1] : (operation[1:0] != 2'b00);
    div_zero = in_div && (operandB == '0);
    overflow = in_div && !operation[0] && (operandA == MIN_NEG) && (operandB == ALL_ONES);
    if (div_zero)
      special_val = operation[1] ? operandA : ALL_ONES;
    else
      special_val = operation[1] ? '0 : MIN_NEG;
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix  = negate ? (~acc + 1'b1) : acc;
    word      = take_high ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    word_fix  = negate ? (~word + 1'b1) : word;
    if (is_div)
      fixed = word_fix;
    else
      fixed = take_high ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
  end

  assign stallRequest = ((state == IDLE) && start && !flush) || (state == RUN) || (state == FIXUP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      acc         <= '0;
      opb         <= '0;
      is_div      <= 1'b0;
      take_high   <= 1'b0;
      negate      <= 1'b0;
      result      <= '0;
      resultValid <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      counter     <= '0;
      resultValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero || overflow) begin
              result      <= special_val;
              resultValid <= 1'b1;
              state       <= DONE;
            end else begin
              acc       <= {{WIDTH{1'b0}}, mag_a};
              opb       <= mag_b;
              is_div    <= in_div;
              take_high <= high_in;
              negate    <= neg_in;
              counter   <= CW'(WIDTH - 1);
              state     <= RUN;
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (counter == '0)
            state <= FIXUP;
          else
            counter <= counter - 1'b1;
        end
        FIXUP: begin
          result      <= fixed;
          resultValid <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (!stall) begin
            resultValid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed RV32M results, latency, stall hold, flush and reset abort.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        flush;
  logic        stall;
  logic        stallRequest;
  logic        resultValid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .operation    (operation),
    .operandA     (operandA),
    .operandB     (operandB),
    .flush        (flush),
    .stall        (stall),
    .stallRequest (stallRequest),
    .resultValid  (resultValid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the first DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit stall_ok;
    start = 1'b1; operation = op; operandA = a; operandB = b;
    #1 stall_ok = (stallRequest === 1'b1);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      operandA = $urandom;
      operandB = $urandom;
      operation = 3'($urandom);
      #1 cyc++;
      if (resultValid === 1'b1) break;
      if (stallRequest !== 1'b1) stall_ok = 0;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " stall busy"}, 64'(stall_ok), 64'd1);
    check({tag, " stall done"}, 64'(stallRequest), 64'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start = 1'b1; operation = 3'b000; operandA = '0; operandB = '0;
    flush = 1'b0; stall = 1'b0;
    @(negedge clk); #1;
    check("reset result", 64'(result), 64'd0);
    check("reset valid", 64'(resultValid), 64'd0);
    check("reset stallreq start", 64'(stallRequest), 64'd1);
    flush = 1'b1; #1;
    check("reset stallreq flush", 64'(stallRequest), 64'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // start coincident with flush is not accepted
    start = 1'b1; flush = 1'b1; #1;
    check("start+flush stallreq", 64'(stallRequest), 64'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0; #1;
    check("start+flush idle", 64'(stallRequest), 64'd0);
    check("start+flush valid", 64'(resultValid), 64'd0);

    do_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    @(negedge clk);
    do_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    @(negedge clk);
    do_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    @(negedge clk);
    do_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    @(negedge clk);
    do_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    @(negedge clk);
    do_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    @(negedge clk);
    do_op("DIVU",   3'b101, 32'd100,      32'd7,         32'd14,        34);
    @(negedge clk);
    do_op("REMU",   3'b111, 32'd100,      32'd7,         32'd2,         34);
    @(negedge clk);
    do_op("DIVU0",  3'b101, 32'h1234,     32'd0,         32'hFFFF_FFFF, 1);
    @(negedge clk);
    do_op("REM0",   3'b110, 32'h1234,     32'd0,         32'h0000_1234, 1);
    @(negedge clk);
    do_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    @(negedge clk);
    do_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    @(negedge clk);
    do_op("MULneg", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34);

    // stall holds DONE
    @(negedge clk);
    stall = 1'b1;
    do_op("STALL", 3'b000, 32'd12, 32'd13, 32'd156, 34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("stall hold valid", 64'(resultValid), 64'd1);
      check("stall hold result", 64'(result), 64'd156);
    end
    stall = 1'b0;
    @(negedge clk); #1;
    check("stall release valid", 64'(resultValid), 64'd0);
    check("stall release stallreq", 64'(stallRequest), 64'd0);
    do_op("B2B", 3'b101, 32'd1000, 32'd10, 32'd100, 34);

    // flush at RUN cycle 10
    @(negedge clk);
    start = 1'b1; operation = 3'b000; operandA = 32'd5; operandB = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    check("flush idle stallreq", 64'(stallRequest), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resultValid === 1'b1) seen = 1;
    end
    check("flush no valid", 64'(seen), 64'd0);

    // reset at RUN cycle 20
    start = 1'b1; operation = 3'b011; operandA = 32'hFFFF_FFFF; operandB = 32'h1234_5678;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0; #1;
    check("midreset result", 64'(result), 64'd0);
    check("midreset valid", 64'(resultValid), 64'd0);
    check("midreset stallreq", 64'(stallRequest), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    do_op("POSTRST", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
